// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Multiplexed 7-segment scan controller for NDIG common-anode digits that share
// one segment bus. Each digit owns a slot of SCAN_DIV clocks. The slot opens with
// BLANK_CYC dead cycles that keep every select off, so the segment bus can settle
// on the new digit's pattern before its anode turns on. The rest of the slot is
// divided into 16 brightness units.
// All display inputs are captured together at the frame boundary. This keeps a
// frame from ever mixing old and new data.

module seg7_scan_ctrl #(
  parameter int NDIG         = 8,
  parameter int SCAN_DIV     = 16384,
  parameter int BLANK_CYC    = 64,
  parameter int BLINK_FRAMES = 32,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              disp_mode,
  input  logic [8*NDIG-1:0] i_data,
  input  logic [NDIG-1:0]   i_dp,
  input  logic              i_blank_lz,
  input  logic [NDIG-1:0]   i_blink_mask,
  input  logic [3:0]        i_bright,
  output logic [7:0]        o_seg,
  output logic [NDIG-1:0]   o_sel,
  output logic              o_frame
);

  localparam int CW   = $clog2(SCAN_DIV);
  localparam int OW   = CW + 1;
  localparam int DW   = $clog2(NDIG);
  localparam int BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int UNIT = (SCAN_DIV - BLANK_CYC) / 16;

  localparam logic [OW-1:0]   UNIT_V   = OW'(UNIT);
  localparam logic [OW-1:0]   BLANK_V  = OW'(BLANK_CYC);
  localparam logic [NDIG-1:0] SEL_ONE  = {{(NDIG-1){1'b0}}, 1'b1};
  localparam logic [7:0]      SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NDIG-1:0] SEL_OFF  = (ACTIVE_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

  // Scan position
  logic [CW-1:0]     cnt;
  logic [DW-1:0]     dig;
  logic              slot_end;
  logic              last_dig;
  logic              frame_end;

  // Blink state
  logic [BW-1:0]     blink_cnt;
  logic              blink_phase;

  // Frame-synchronous shadow copies of the inputs
  logic              sh_mode;
  logic [8*NDIG-1:0] sh_data;
  logic [NDIG-1:0]   sh_dp;
  logic              sh_lz;
  logic [NDIG-1:0]   sh_mask;
  logic [3:0]        sh_bright;

  // Decode path, working in active-low polarity until the output register
  logic [3:0]        nib;
  logic [7:0]        raw_byte;
  logic [7:0]        hex_code;
  logic [7:0]        cur_code;
  logic [NDIG-1:0]   lz_sup;
  logic              lz_run;
  logic              dig_sup;
  logic [7:0]        seg_al;
  logic [OW-1:0]     cnt_ext;
  logic [OW-1:0]     rel;
  logic [OW-1:0]     on_len;
  logic              in_window;
  logic [NDIG-1:0]   sel_al;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign slot_end  = (cnt == CW'(SCAN_DIV - 1));
  assign last_dig  = (dig == DW'(NDIG - 1));
  assign frame_end = slot_end && last_dig;

  // Slot counter and digit index. The digit advances on the last cycle of each slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      dig <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      dig <= last_dig ? '0 : dig + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Blink phase flips after every BLINK_FRAMES completed frames.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Capture every display input at the frame boundary only, so a frame never tears.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_mode   <= 1'b0;
      sh_data   <= '0;
      sh_dp     <= '0;
      sh_lz     <= 1'b0;
      sh_mask   <= '0;
      sh_bright <= 4'd0;
    end else if (frame_end) begin
      sh_mode   <= disp_mode;
      sh_data   <= i_data;
      sh_dp     <= i_dp;
      sh_lz     <= i_blank_lz;
      sh_mask   <= i_blink_mask;
      sh_bright <= i_bright;
    end
  end

  // Leading-zero map. A digit is suppressible when it and every digit above it are zero.
  always_comb begin
    lz_run = 1'b1;
    lz_sup = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      lz_run    = lz_run & (sh_data[4*i +: 4] == 4'd0);
      lz_sup[i] = lz_run;
    end
  end

  assign nib       = sh_data[4*int'(dig) +: 4];
  assign raw_byte  = sh_data[8*int'(dig) +: 8];
  assign hex_code  = hex_to_seg(nib) & ~{sh_dp[dig], 7'b0};
  assign cur_code  = sh_mode ? raw_byte : hex_code;

  assign dig_sup   = (!sh_mode && sh_lz && lz_sup[dig]) || (blink_phase && sh_mask[dig]);
  assign seg_al    = dig_sup ? 8'hFF : cur_code;

  assign cnt_ext   = {1'b0, cnt};
  assign rel       = cnt_ext - BLANK_V;
  assign on_len    = UNIT_V * (OW'(sh_bright) + OW'(1));
  assign in_window = (cnt_ext >= BLANK_V) && (rel < on_len);
  assign sel_al    = (in_window && !dig_sup) ? ~(SEL_ONE << dig) : {NDIG{1'b1}};

  // Register segments, selects and the frame pulse together so they stay aligned.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_seg   <= SEG_OFF;
      o_sel   <= SEL_OFF;
      o_frame <= 1'b0;
    end else begin
      o_seg   <= (ACTIVE_LOW != 0) ? seg_al : ~seg_al;
      o_sel   <= (ACTIVE_LOW != 0) ? sel_al : ~sel_al;
      o_frame <= frame_end;
    end
  end

endmodule
